seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 217 +++++++++++++++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider -- parametrised multi-cycle radix-2 restoring integer divider.
//
// Produces quotient (truncated toward zero) and remainder (sign follows the
// dividend in signed mode) with valid/ready handshakes on both sides.
// Zero divisor and signed divide-by-minus-one bypass the iteration loop.
//
// Optional build macro: SEQ_DIVIDER_EARLY_TERM_EN
//   When defined, the dividend magnitude is pre-normalised by its leading-zero
//   count so the iteration loop only covers significant bits. A zero dividend
//   skips the loop entirely. Results are identical to the default build; only
//   latency changes.
//
// Ports:
//   clock        sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     operands present
//   in_ready     block can accept operands (high only in IDLE)
//   dividend     numerator, DIVIDEND_WIDTH bits
//   divisor      denominator, DIVISOR_WIDTH bits
//   out_valid    results present, held until out_ready
//   out_ready    consumer takes results
//   quotient     DIVIDEND_WIDTH-bit result
//   remainder    DIVISOR_WIDTH-bit result
//   div_by_zero  divisor was zero for this result
//   overflow     signed MIN / -1 for this result
module seq_divider #(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32,
    parameter bit SIGNED         = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero,
    output logic                      overflow
);

    localparam int DDW = DIVIDEND_WIDTH;
    localparam int DVW = DIVISOR_WIDTH;
    localparam int CW  = $clog2(DDW);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [DDW-1:0] dvd_r;       // captured dividend
    logic [DVW-1:0] dvs_r;       // captured divisor
    logic [DDW-1:0] q_r;         // dividend bits shift out the top, quotient bits in at the bottom
    logic [DVW:0]   prem;        // partial remainder
    logic [DVW-1:0] dvs_mag_r;   // |divisor|
    logic [CW-1:0]  cnt;         // iterations remaining minus one
    logic           neg_q;
    logic           neg_r;
    logic           special;     // result already final in q_r/prem, skip sign fix-up
    logic           dz_r;
    logic           ov_r;

    // ---------------- PREP-stage combinational helpers ----------------
    logic           dvd_neg, dvs_neg;
    logic [DDW-1:0] dvd_mag;
    logic [DVW-1:0] dvs_mag;
    logic           dvs_zero, dvs_m1, dvd_min;

    assign dvd_neg  = SIGNED && dvd_r[DDW-1];
    assign dvs_neg  = SIGNED && dvs_r[DVW-1];
    // MIN negates to itself, which read as unsigned is exactly its magnitude.
    assign dvd_mag  = dvd_neg ? -dvd_r : dvd_r;
    assign dvs_mag  = dvs_neg ? -dvs_r : dvs_r;
    assign dvs_zero = (dvs_r == '0);
    assign dvs_m1   = SIGNED && (dvs_r == '1);
    assign dvd_min  = SIGNED && (dvd_r == {1'b1, {(DDW-1){1'b0}}});

`ifdef SEQ_DIVIDER_EARLY_TERM_EN
    logic          dvd_zero;
    logic [CW-1:0] lz;

    assign dvd_zero = (dvd_r == '0);

    // Leading-zero count of |dividend|; the highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < DDW; i++) begin
            if (dvd_mag[i]) lz = CW'(DDW - 1 - i);
        end
    end
`endif

    // ---------------- ITER-stage combinational helpers ----------------
    logic [DVW+1:0] shifted;
    logic [DVW:0]   diff;
    logic           fits;

    // prem < |divisor| always, so the shifted value stays below 2*|divisor|.
    assign shifted = {prem, q_r[DDW-1]};
    assign fits    = (shifted >= {2'b00, dvs_mag_r});
    assign diff    = shifted[DVW:0] - {1'b0, dvs_mag_r};

    assign in_ready = (state == IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = PREP;
            PREP: begin
                if (dvs_zero || dvs_m1)
                    state_nxt = FIX;
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
                else if (dvd_zero)
                    state_nxt = FIX;
`endif
                else
                    state_nxt = ITER;
            end
            ITER: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dvd_r       <= '0;
            dvs_r       <= '0;
            q_r         <= '0;
            prem        <= '0;
            dvs_mag_r   <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            special     <= 1'b0;
            dz_r        <= 1'b0;
            ov_r        <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_r       <= dividend;
                        dvs_r       <= divisor;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                PREP: begin
                    neg_q     <= dvd_neg ^ dvs_neg;
                    neg_r     <= dvd_neg;
                    dvs_mag_r <= dvs_mag;
                    prem      <= '0;
                    special   <= 1'b0;
                    dz_r      <= 1'b0;
                    ov_r      <= 1'b0;
                    if (dvs_zero) begin
                        special <= 1'b1;
                        dz_r    <= 1'b1;
                        q_r     <= '1;
                        prem    <= {1'b0, dvd_r[DVW-1:0]};
                    end else if (dvs_m1) begin
                        // Wrapping negate: MIN / -1 yields MIN and flags overflow.
                        special <= 1'b1;
                        q_r     <= -dvd_r;
                        ov_r    <= dvd_min;
                    end
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
                    else if (dvd_zero) begin
                        q_r <= '0;
                    end else begin
                        // Leading zeros would only produce zero quotient bits.
                        q_r <= dvd_mag << lz;
                        cnt <= CW'(DDW - 1) - lz;
                    end
`else
                    else begin
                        q_r <= dvd_mag;
                        cnt <= CW'(DDW - 1);
                    end
`endif
                end
                ITER: begin
                    prem <= fits ? diff : shifted[DVW:0];
                    q_r  <= {q_r[DDW-2:0], fits};
                    cnt  <= cnt - 1'b1;
                end
                FIX: begin
                    quotient    <= (neg_q && !special) ? -q_r : q_r;
                    remainder   <= (neg_r && !special) ? -prem[DVW-1:0] : prem[DVW-1:0];
                    div_by_zero <= dz_r;
                    overflow    <= ov_r;
                    out_valid   <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: one signed (16/8) and one unsigned (16/8) instance,
// directed steps plus a short random pass, with a scoreboard queue of
// expected results.
module tb_seq_divider;

    logic        clk;
    logic        reset_n;
    logic        iv   [2];
    logic        ir   [2];
    logic [15:0] dvd  [2];
    logic [7:0]  dvs  [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [15:0] q    [2];
    logic [7:0]  r    [2];
    logic        dz   [2];
    logic        ovf  [2];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        of;
        int          lat;
    } exp_t;

    exp_t scb[$];

    seq_divider #(.DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8), .SIGNED(1'b1)) u_s (
        .clock(clk), .reset_n(reset_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .dividend(dvd[0]), .divisor(dvs[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .quotient(q[0]), .remainder(r[0]),
        .div_by_zero(dz[0]), .overflow(ovf[0])
    );

    seq_divider #(.DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8), .SIGNED(1'b0)) u_u (
        .clock(clk), .reset_n(reset_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .dividend(dvd[1]), .divisor(dvs[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .quotient(q[1]), .remainder(r[1]),
        .div_by_zero(dz[1]), .overflow(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected accept-to-out_valid edges for a non-special division.
    function automatic int lat_of(input int mag);
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
        if (mag == 0) return 2;
        for (int i = 15; i >= 0; i--) if (mag[i]) return i + 3;
        return 2;
`else
        return (mag >= 0) ? 18 : 18;
`endif
    endfunction

    // Reference model from plain integer arithmetic.
    function automatic exp_t model(input int d, input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        int sa, sbv;
        e.dz = 1'b0; e.of = 1'b0;
        if (b == 8'h00) begin
            e.q = 16'hFFFF; e.r = a[7:0]; e.dz = 1'b1; e.lat = 2;
        end else if (d == 0 && b == 8'hFF) begin
            e.q = 16'(-int'($signed(a))); e.r = 8'h00; e.of = (a == 16'h8000); e.lat = 2;
        end else if (d == 0) begin
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            e.q = 16'(sa / sbv);
            e.r = 8'(sa % sbv);
            e.lat = lat_of(sa < 0 ? -sa : sa);
        end else begin
            e.q = a / {8'h00, b};
            e.r = 8'(a % {8'h00, b});
            e.lat = lat_of(int'(a));
        end
        return e;
    endfunction

    // Drive one operation on instance d, check latency and results, then
    // hold out_ready low for 'hold' cycles while a stray request is offered.
    task automatic run_op(input int d, input logic [15:0] a, input logic [7:0] b,
                          input exp_t e, input int hold, input string tag);
        exp_t got;
        int n;
        scb.push_back(e);
        chk({tag, " in_ready"}, 32'(ir[d]), 32'd1);
        dvd[d] = a; dvs[d] = b; iv[d] = 1'b1;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        chk({tag, " flags clear at accept"}, {30'd0, dz[d], ovf[d]}, 32'd0);
        for (n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ov[d]) break;
        end
        got = scb.pop_front();
        chk({tag, " latency"}, 32'(n), 32'(got.lat));
        chk({tag, " quotient"}, 32'(q[d]), 32'(got.q));
        chk({tag, " remainder"}, 32'(r[d]), 32'(got.r));
        chk({tag, " div_by_zero"}, 32'(dz[d]), 32'(got.dz));
        chk({tag, " overflow"}, 32'(ovf[d]), 32'(got.of));
        for (int k = 0; k < hold; k++) begin
            iv[d] = 1'b1; dvd[d] = 16'h000A; dvs[d] = 8'h02;
            @(posedge clk); #1;
            chk({tag, " hold out_valid"}, 32'(ov[d]), 32'd1);
            chk({tag, " hold in_ready"}, 32'(ir[d]), 32'd0);
            chk({tag, " hold quotient"}, 32'(q[d]), 32'(got.q));
            chk({tag, " hold remainder"}, 32'(r[d]), 32'(got.r));
        end
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        chk({tag, " out_valid after handshake"}, 32'(ov[d]), 32'd0);
        chk({tag, " in_ready after handshake"}, 32'(ir[d]), 32'd1);
    endtask

    function automatic exp_t mk(input logic [15:0] eq, input logic [7:0] er,
                                input logic edz, input logic eof, input int lat);
        exp_t e;
        e.q = eq; e.r = er; e.dz = edz; e.of = eof; e.lat = lat;
        return e;
    endfunction

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; dvd[i] = '0; dvs[i] = '0; ordy[i] = 1'b1;
        end
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset in_ready", 32'(ir[i]), 32'd1);
            chk("reset out_valid", 32'(ov[i]), 32'd0);
            chk("reset quotient", 32'(q[i]), 32'd0);
            chk("reset remainder", 32'(r[i]), 32'd0);
            chk("reset flags", {30'd0, dz[i], ovf[i]}, 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Signed directed cases
        run_op(0, 16'd100, 8'd7,  mk(16'd14,   8'd2,   1'b0, 1'b0, lat_of(100)), 0, "100/7");
        run_op(0, 16'hFF9C, 8'd7, mk(16'hFFF2, 8'hFE,  1'b0, 1'b0, lat_of(100)), 0, "-100/7");
        run_op(0, 16'd100, 8'hF9, mk(16'hFFF2, 8'd2,   1'b0, 1'b0, lat_of(100)), 0, "100/-7");
        run_op(0, 16'h1234, 8'h00, mk(16'hFFFF, 8'h34, 1'b1, 1'b0, 2), 0, "div0");
        run_op(0, 16'h8000, 8'hFF, mk(16'h8000, 8'h00, 1'b0, 1'b1, 2), 0, "min/-1");
        run_op(0, 16'h0005, 8'hFF, mk(16'hFFFB, 8'h00, 1'b0, 1'b0, 2), 0, "5/-1");
        run_op(0, 16'd3, 8'd1,    mk(16'd3,    8'd0,   1'b0, 1'b0, lat_of(3)), 0, "3/1");

        // Unsigned with back-pressure; stray requests during DONE must be ignored
        ordy[1] = 1'b0;
        run_op(1, 16'hFFFF, 8'hFF, mk(16'h0101, 8'h00, 1'b0, 1'b0, lat_of(16'hFFFF)), 5, "u ffff/ff");
        run_op(1, 16'd1000, 8'd33, mk(16'd30, 8'd10, 1'b0, 1'b0, lat_of(1000)), 0, "u 1000/33");

        // Reset mid-iteration
        dvd[0] = 16'd9999; dvs[0] = 8'd3; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid reset out_valid", 32'(ov[0]), 32'd0);
        chk("mid reset in_ready", 32'(ir[0]), 32'd1);
        chk("mid reset quotient", 32'(q[0]), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post reset out_valid", 32'(ov[0]), 32'd0);
        run_op(0, 16'd50, 8'd5, mk(16'd10, 8'd0, 1'b0, 1'b0, lat_of(50)), 0, "50/5");

        // Random pass against the integer reference model
        for (int k = 0; k < 16; k++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            if (k % 5 == 3) b = 8'h00;
            if (k % 7 == 4) a = 16'h8000;
            run_op(k % 2, a, b, model(k % 2, a, b), 0, (k % 2) ? "rand u" : "rand s");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
